// File: rtl/qupls_regs_seq_pkg.sv
// Shared types and constants for the REGS micro-op sequencer.
// Optional feature macro: QUPLS_REGS_DESCEND_EN (descending register order).
package QuplsPkg;

  localparam int unsigned REGS_MASKW = 16;

  typedef enum logic {
    IDLE = 1'b0,
    SEQ  = 1'b1
  } regs_seq_state_t;

endpackage

// File: rtl/qupls_regs_seq_ffo.sv
// Priority select over a register-group mask: lowest set bit, or highest set
// bit when descending order is built in (QUPLS_REGS_DESCEND_EN) and dir=1.
module qupls_regs_ffo #(
  parameter int unsigned MASKW = 16,
  parameter int unsigned IW    = (MASKW > 1) ? $clog2(MASKW) : 1
) (
  input  logic [MASKW-1:0] mask,
  input  logic             dir,
  output logic [IW-1:0]    idx,
  output logic             found
);

  // Scan order decides which set bit wins.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = int'(MASKW) - 1; i >= 0; i--) begin
      if (mask[i]) begin
        idx   = IW'(i);
        found = 1'b1;
      end
    end
`ifdef QUPLS_REGS_DESCEND_EN
    if (dir) begin
      idx   = '0;
      found = 1'b0;
      for (int i = 0; i < int'(MASKW); i++) begin
        if (mask[i]) begin
          idx   = IW'(i);
          found = 1'b1;
        end
      end
    end
`endif
  end

`ifndef QUPLS_REGS_DESCEND_EN
  // Direction has no effect in an ascending-only build.
  logic unused_dir;
  assign unused_dir = dir;
`endif

endmodule

// File: rtl/qupls_regs_seq.sv
// REGS instruction sequencer: expands a register-group mask into one micro-op
// per set bit, with registered handshake outputs.
// Optional feature macro: QUPLS_REGS_DESCEND_EN (in_dir selects descending order).
module qupls_regs_seq
  import QuplsPkg::*;
#(
  parameter int unsigned MASKW = REGS_MASKW,
  parameter int unsigned RW    = 7
) (
  input  logic                     rst,
  input  logic                     clk,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_regs,
  input  logic [MASKW-1:0]         in_mask,
  input  logic [RW-1:0]            in_base,
  input  logic                     in_dir,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [RW-1:0]            out_reg,
  output logic [$clog2(MASKW)-1:0] out_idx,
  output logic                     out_first,
  output logic                     out_last,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned IW = (MASKW > 1) ? $clog2(MASKW) : 1;

  regs_seq_state_t state;
  logic [MASKW-1:0] mask_r;
  logic [RW-1:0]    base_r;
  logic             dir_r;
  logic [IW-1:0]    sel_r;

  logic             accept;
  logic             hs;
  logic [MASKW-1:0] mask_nxt;
  logic             dir_nxt;
  logic [RW-1:0]    base_nxt;
  logic [IW-1:0]    sel_nxt;
  logic             found_nxt;
  logic             last_nxt;

  assign accept = in_valid & in_ready & in_regs & ~flush;
  assign hs     = out_valid & out_ready;

  // Mask as it will be after this edge, so the next micro-op can be registered.
  always_comb begin
    mask_nxt = mask_r;
    dir_nxt  = dir_r;
    base_nxt = base_r;
    if (state == IDLE) begin
      mask_nxt = in_mask;
      dir_nxt  = in_dir;
      base_nxt = in_base;
    end else if (hs) begin
      mask_nxt = mask_r & ~(MASKW'(1) << sel_r);
    end
    last_nxt = (mask_nxt & (mask_nxt - MASKW'(1))) == '0;
  end

  qupls_regs_ffo #(.MASKW(MASKW), .IW(IW)) u_ffo (
    .mask  (mask_nxt),
    .dir   (dir_nxt),
    .idx   (sel_nxt),
    .found (found_nxt)
  );

  // Sequencer state and registered micro-op outputs.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
      out_reg   <= '0;
      out_idx   <= '0;
      mask_r    <= '0;
      base_r    <= '0;
      dir_r     <= 1'b0;
      sel_r     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (found_nxt) begin
              state     <= SEQ;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              busy      <= 1'b1;
              mask_r    <= mask_nxt;
              base_r    <= base_nxt;
              dir_r     <= dir_nxt;
              sel_r     <= sel_nxt;
              out_reg   <= base_nxt + RW'(sel_nxt);
              out_idx   <= '0;
              out_first <= 1'b1;
              out_last  <= last_nxt;
            end else begin
              done <= 1'b1;
            end
          end
        end
        SEQ: begin
          if (hs) begin
            if (out_last) begin
              state     <= IDLE;
              in_ready  <= 1'b1;
              out_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              out_first <= 1'b0;
              out_last  <= 1'b0;
              mask_r    <= '0;
            end else begin
              mask_r    <= mask_nxt;
              sel_r     <= sel_nxt;
              out_reg   <= base_r + RW'(sel_nxt);
              out_idx   <= out_idx + IW'(1);
              out_first <= 1'b0;
              out_last  <= last_nxt;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qupls_regs_seq.sv
// Directed bench for qupls_regs_seq with hand-computed expectations.
module tb_qupls_regs_seq;

  localparam int unsigned MASKW = 16;
  localparam int unsigned RW    = 7;

  logic             rst, clk, flush, in_valid, in_ready, in_regs, in_dir;
  logic [MASKW-1:0] in_mask;
  logic [RW-1:0]    in_base;
  logic             out_valid, out_ready, out_first, out_last, busy, done;
  logic [RW-1:0]    out_reg;
  logic [3:0]       out_idx;

  int n_cmp = 0;
  int n_err = 0;

  qupls_regs_seq #(.MASKW(MASKW), .RW(RW)) dut (
    .rst(rst), .clk(clk), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_regs(in_regs), .in_mask(in_mask), .in_base(in_base), .in_dir(in_dir),
    .out_valid(out_valid), .out_ready(out_ready), .out_reg(out_reg), .out_idx(out_idx),
    .out_first(out_first), .out_last(out_last), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks a micro-op: valid, reg, idx, first, last.
  task automatic chk_uop(input string tag, input int r, input int i, input bit f, input bit l);
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".reg"},   32'(out_reg),   32'(r));
    chk({tag, ".idx"},   32'(out_idx),   32'(i));
    chk({tag, ".first"}, 32'(out_first), 32'(f));
    chk({tag, ".last"},  32'(out_last),  32'(l));
  endtask

  task automatic chk_idle(input string tag, input bit d);
    chk({tag, ".valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".ready"}, 32'(in_ready),  32'd1);
    chk({tag, ".busy"},  32'(busy),      32'd0);
    chk({tag, ".done"},  32'(done),      32'(d));
  endtask

  task automatic issue(input logic [MASKW-1:0] m, input logic [RW-1:0] b, input logic d);
    in_valid = 1'b1; in_regs = 1'b1; in_mask = m; in_base = b; in_dir = d;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_regs = 1'b0; in_mask = '0;
    in_base = '0; in_dir = 1'b0; out_ready = 1'b1;
    tick(); tick();
    chk_idle("reset", 1'b0);
    chk("reset.reg", 32'(out_reg), 32'd0);
    chk("reset.idx", 32'(out_idx), 32'd0);
    chk("reset.first", 32'(out_first), 32'd0);
    chk("reset.last", 32'(out_last), 32'd0);
    rst = 1'b0;
    tick();

    // Ascending: 8,10,12 then done.
    issue(16'h0015, 7'd8, 1'b0);
    chk_uop("asc0", 8, 0, 1, 0);
    chk("asc0.busy", 32'(busy), 32'd1);
    chk("asc0.inready", 32'(in_ready), 32'd0);
    tick(); chk_uop("asc1", 10, 1, 0, 0);
    tick(); chk_uop("asc2", 12, 2, 0, 1);
    tick(); chk_idle("asc.end", 1'b1);
    tick(); chk_idle("asc.after", 1'b0);

    // Direction request: honoured only in a descending build.
    issue(16'h0015, 7'd8, 1'b1);
`ifdef QUPLS_REGS_DESCEND_EN
    chk_uop("dsc0", 12, 0, 1, 0);
    tick(); chk_uop("dsc1", 10, 1, 0, 0);
    tick(); chk_uop("dsc2", 8, 2, 0, 1);
`else
    chk_uop("dsc0", 8, 0, 1, 0);
    tick(); chk_uop("dsc1", 10, 1, 0, 0);
    tick(); chk_uop("dsc2", 12, 2, 0, 1);
`endif
    tick(); chk_idle("dsc.end", 1'b1);
    tick();

    // Backpressure: reg 8 held three cycles, then 9.
    out_ready = 1'b0;
    issue(16'h0003, 7'd8, 1'b0);
    chk_uop("bp0", 8, 0, 1, 0);
    tick(); chk_uop("bp1", 8, 0, 1, 0);
    tick(); chk_uop("bp2", 8, 0, 1, 0);
    out_ready = 1'b1;
    tick(); chk_uop("bp3", 9, 1, 0, 1);
    tick(); chk_idle("bp.end", 1'b1);
    tick();

    // Empty mask: no micro-op, done one cycle after accept.
    issue(16'h0000, 7'd5, 1'b0);
    chk_idle("empty", 1'b1);
    tick(); chk_idle("empty.after", 1'b0);

    // Non-REGS instruction ignored.
    in_valid = 1'b1; in_regs = 1'b0; in_mask = 16'h00ff; in_base = 7'd3;
    tick(); in_valid = 1'b0;
    chk_idle("notregs", 1'b0);
    tick(); chk_idle("notregs.after", 1'b0);

    // Accept blocked by flush.
    flush = 1'b1;
    issue(16'h00ff, 7'd3, 1'b0);
    flush = 1'b0;
    chk_idle("flushacc", 1'b0);

    // Register number wraps past the top.
    issue(16'h0009, 7'd126, 1'b0);
    chk_uop("wrap0", 126, 0, 1, 0);
    tick(); chk_uop("wrap1", 1, 1, 0, 1);
    tick(); chk_idle("wrap.end", 1'b1);
    tick();

    // Full mask: 16 consecutive micro-ops.
    issue(16'hffff, 7'd0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      chk_uop($sformatf("full%0d", i), i, i, i == 0, i == 15);
      tick();
    end
    chk_idle("full.end", 1'b1);
    tick();

    // Flush after five handshakes.
    issue(16'hffff, 7'd0, 1'b0);
    repeat (5) tick();
    chk_uop("fl5", 5, 5, 0, 0);
    flush = 1'b1;
    tick(); flush = 1'b0;
    chk_idle("flush", 1'b0);
    tick(); chk_idle("flush.after", 1'b0);

    // Flush together with the final handshake.
    issue(16'h0003, 7'd20, 1'b0);
    tick(); chk_uop("fllast", 21, 1, 0, 1);
    flush = 1'b1;
    tick(); flush = 1'b0;
    chk_idle("fllast.end", 1'b0);
    tick(); chk_idle("fllast.after", 1'b0);

    // Reset mid-sequence, then a fresh sequence.
    issue(16'hffff, 7'd0, 1'b0);
    tick();
    rst = 1'b1;
    tick(); rst = 1'b0;
    chk_idle("rstmid", 1'b0);
    chk("rstmid.reg", 32'(out_reg), 32'd0);
    chk("rstmid.idx", 32'(out_idx), 32'd0);
    chk("rstmid.last", 32'(out_last), 32'd0);
    tick(); chk_idle("rstmid.after", 1'b0);
    issue(16'h0015, 7'd8, 1'b0);
    chk_uop("post0", 8, 0, 1, 0);
    tick(); chk_uop("post1", 10, 1, 0, 0);
    tick(); chk_uop("post2", 12, 2, 0, 1);
    tick(); chk_idle("post.end", 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
